// File: rtl/output_port_allocator_pkg.sv
// Shared router definitions: port numbering, allocator FSM encoding and default sizing.
package output_port_allocator_pkg;
  localparam int NUM_PORTS   = 5;
  localparam int PORT_CORE   = 0;
  localparam int PORT_L1     = 1;
  localparam int PORT_L2     = 2;
  localparam int PORT_L3     = 3;
  localparam int PORT_L4     = 4;

  localparam int DEF_NUM_REQ = NUM_PORTS - 1;
  localparam int DEF_CREDITS = 4;
  localparam int DEF_CNT_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    ALLOC = 1'b1
  } alloc_state_e;
endpackage

// File: rtl/output_port_allocator_if.sv
// Crossbar <-> output-port allocator signal bundle.
interface output_port_allocator_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 3
);
  logic [NUM_REQ-1:0] req_in;
  logic               flit_vld_in;
  logic               tail_in;
  logic               credit_in;
  logic [NUM_REQ-1:0] gnt_out;
  logic               busy;
  logic               credit_ok;
  logic [CNT_W-1:0]   credit_cnt;
  logic               err;

  modport master (
    output req_in, flit_vld_in, tail_in, credit_in,
    input  gnt_out, busy, credit_ok, credit_cnt, err
  );

  modport slave (
    input  req_in, flit_vld_in, tail_in, credit_in,
    output gnt_out, busy, credit_ok, credit_cnt, err
  );
endinterface

// File: rtl/output_port_allocator_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module output_port_allocator_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        idx    = IW'(j);
        gnt[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/output_port_allocator.sv
// Output-port allocator: round-robin packet grant held head..tail, gated by a
// downstream credit counter, with a sticky protocol-error flag.
module output_port_allocator
  import output_port_allocator_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int CREDITS = DEF_CREDITS,
  parameter int CNT_W   = DEF_CNT_W
) (
  input logic                    clk,
  input logic                    rst,
  output_port_allocator_if.slave bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CREDITS);
  localparam logic [IW-1:0]    IDX_MAX = IW'(NUM_REQ - 1);

  alloc_state_e       state, state_nxt;
  logic [NUM_REQ-1:0] gnt_q, gnt_nxt, arb_gnt;
  logic [IW-1:0]      win_q, win_nxt, ptr_q, ptr_nxt, arb_idx;
  logic               arb_any;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_q;
  logic               credit_avail, flit_ok, release_pkt;

  assign credit_avail = (cnt_q != '0);
  assign flit_ok      = bus.flit_vld_in && (state == ALLOC);
  assign release_pkt  = (bus.flit_vld_in && bus.tail_in) || !bus.req_in[win_q];

  output_port_allocator_rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req (bus.req_in),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_q;
    win_nxt   = win_q;
    ptr_nxt   = ptr_q;
    case (state)
      IDLE: begin
        if (arb_any && credit_avail) begin
          state_nxt = ALLOC;
          gnt_nxt   = arb_gnt;
          win_nxt   = arb_idx;
        end
      end
      ALLOC: begin
        // Tail or abort releases; the winner drops to lowest priority.
        if (release_pkt) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          ptr_nxt   = (win_q == IDX_MAX) ? '0 : win_q + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt_q <= '0;
      win_q <= '0;
      ptr_q <= '0;
    end else begin
      state <= state_nxt;
      gnt_q <= gnt_nxt;
      win_q <= win_nxt;
      ptr_q <= ptr_nxt;
    end
  end

  // Credits run independently of the FSM; out-of-range events saturate and flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= CNT_MAX;
      err_q <= 1'b0;
    end else begin
      if (bus.flit_vld_in && (state == IDLE)) err_q <= 1'b1;
      if (flit_ok && !bus.credit_in) begin
        if (cnt_q == '0) err_q <= 1'b1;
        else             cnt_q <= cnt_q - 1'b1;
      end else if (bus.credit_in && !flit_ok) begin
        if (cnt_q == CNT_MAX) err_q <= 1'b1;
        else                  cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.gnt_out    = gnt_q;
  assign bus.busy       = (state == ALLOC);
  assign bus.credit_ok  = credit_avail;
  assign bus.credit_cnt = cnt_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_output_port_allocator.sv
// Directed scenarios plus randomized traffic against a packet-level reference model.
module tb_output_port_allocator;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  output_port_allocator_if #(.NUM_REQ(4), .CNT_W(3)) bus ();

  output_port_allocator #(.NUM_REQ(4), .CREDITS(4), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: whether a packet owns the port, who owns it, next priority, credits, error.
  bit         m_busy;
  int         m_win, m_ptr, m_cnt;
  bit         m_err;
  logic [3:0] m_gnt;

  task automatic step(input bit rs, input logic [3:0] r, input bit f, input bit t, input bit c);
    int  old_cnt;
    bit  found;
    rst             = rs;
    bus.req_in      = r;
    bus.flit_vld_in = f;
    bus.tail_in     = t;
    bus.credit_in   = c;
    @(posedge clk);
    if (rs) begin
      m_busy = 0; m_win = 0; m_ptr = 0; m_cnt = 4; m_err = 0;
    end else begin
      old_cnt = m_cnt;
      if (f && !m_busy) m_err = 1;
      if (f && m_busy && !c) begin
        if (m_cnt == 0) m_err = 1; else m_cnt = m_cnt - 1;
      end else if (c && !(f && m_busy)) begin
        if (m_cnt == 4) m_err = 1; else m_cnt = m_cnt + 1;
      end
      if (!m_busy) begin
        if (r != 4'b0 && old_cnt != 0) begin
          found = 0;
          for (int k = 0; k < 4; k++)
            if (!found && r[(m_ptr + k) % 4]) begin found = 1; m_win = (m_ptr + k) % 4; end
          m_busy = 1;
        end
      end else if ((f && t) || !r[m_win]) begin
        m_busy = 0;
        m_ptr  = (m_win + 1) % 4;
      end
    end
    m_gnt = m_busy ? 4'(1 << m_win) : 4'b0;
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    step(1, 4'b0000, 0, 0, 0);
    total++; if (bus.gnt_out !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b exp=0000", bus.gnt_out); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.credit_cnt !== 3'd4) begin bad++; $display("FAIL reset_cnt got=%0d exp=4", bus.credit_cnt); end
    total++; if (bus.credit_ok !== 1'b1) begin bad++; $display("FAIL reset_credit_ok got=%b exp=1", bus.credit_ok); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.err); end
  endtask

  task automatic test_grant_and_rr();
    step(0, 4'b0101, 0, 0, 0);
    total++; if (bus.gnt_out !== 4'b0001) begin bad++; $display("FAIL first_gnt got=%b exp=0001", bus.gnt_out); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL first_busy got=%b exp=1", bus.busy); end
    total++; if (bus.credit_cnt !== 3'd4) begin bad++; $display("FAIL first_cnt got=%0d exp=4", bus.credit_cnt); end
    step(0, 4'b0101, 1, 0, 0);
    step(0, 4'b0101, 1, 0, 0);
    total++; if (bus.gnt_out !== 4'b0001) begin bad++; $display("FAIL hold_gnt got=%b exp=0001", bus.gnt_out); end
    step(0, 4'b0101, 1, 1, 0);
    total++; if (bus.gnt_out !== 4'b0000) begin bad++; $display("FAIL release_gnt got=%b exp=0000", bus.gnt_out); end
    total++; if (bus.credit_cnt !== 3'd1) begin bad++; $display("FAIL three_flit_cnt got=%0d exp=1", bus.credit_cnt); end
    step(0, 4'b0101, 0, 0, 0);
    total++; if (bus.gnt_out !== 4'b0100) begin bad++; $display("FAIL rr_next_gnt got=%b exp=0100", bus.gnt_out); end
  endtask

  task automatic test_credit_exhaust();
    step(1, 4'b0000, 0, 0, 0);
    step(0, 4'b0001, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 4'b0001, 1, 0, 0);
    total++; if (bus.credit_cnt !== 3'd0) begin bad++; $display("FAIL exhaust_cnt got=%0d exp=0", bus.credit_cnt); end
    total++; if (bus.credit_ok !== 1'b0) begin bad++; $display("FAIL exhaust_ok got=%b exp=0", bus.credit_ok); end
    total++; if (bus.gnt_out !== 4'b0001) begin bad++; $display("FAIL exhaust_gnt_held got=%b exp=0001", bus.gnt_out); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL exhaust_err_early got=%b exp=0", bus.err); end
    step(0, 4'b0001, 1, 0, 0);
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL underflow_err got=%b exp=1", bus.err); end
    total++; if (bus.credit_cnt !== 3'd0) begin bad++; $display("FAIL underflow_cnt got=%0d exp=0", bus.credit_cnt); end
    step(0, 4'b0001, 0, 0, 1);
    total++; if (bus.credit_cnt !== 3'd1) begin bad++; $display("FAIL credit_return_cnt got=%0d exp=1", bus.credit_cnt); end
    total++; if (bus.credit_ok !== 1'b1) begin bad++; $display("FAIL credit_return_ok got=%b exp=1", bus.credit_ok); end
  endtask

  task automatic test_same_cycle_and_overflow();
    step(1, 4'b0000, 0, 0, 0);
    step(0, 4'b0010, 0, 0, 0);
    step(0, 4'b0010, 1, 0, 0);
    step(0, 4'b0010, 1, 0, 0);
    step(0, 4'b0010, 1, 0, 1);
    total++; if (bus.credit_cnt !== 3'd2) begin bad++; $display("FAIL same_cycle_cnt got=%0d exp=2", bus.credit_cnt); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL same_cycle_err got=%b exp=0", bus.err); end
    step(0, 4'b0000, 0, 0, 0);
    step(0, 4'b0000, 0, 0, 1);
    step(0, 4'b0000, 0, 0, 1);
    total++; if (bus.credit_cnt !== 3'd4 || bus.err !== 1'b0) begin bad++; $display("FAIL refill got cnt=%0d err=%b exp cnt=4 err=0", bus.credit_cnt, bus.err); end
    step(0, 4'b0000, 0, 0, 1);
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL overflow_err got=%b exp=1", bus.err); end
    total++; if (bus.credit_cnt !== 3'd4) begin bad++; $display("FAIL overflow_cnt got=%0d exp=4", bus.credit_cnt); end
  endtask

  task automatic test_abort_and_reset();
    step(1, 4'b0000, 0, 0, 0);
    step(0, 4'b0000, 1, 0, 0);
    total++; if (bus.err !== 1'b1 || bus.credit_cnt !== 3'd4) begin bad++; $display("FAIL idle_flit got err=%b cnt=%0d exp err=1 cnt=4", bus.err, bus.credit_cnt); end
    step(0, 4'b0010, 0, 0, 0);
    total++; if (bus.gnt_out !== 4'b0010) begin bad++; $display("FAIL abort_setup_gnt got=%b exp=0010", bus.gnt_out); end
    step(0, 4'b0000, 0, 0, 0);
    total++; if (bus.gnt_out !== 4'b0000 || bus.busy !== 1'b0) begin bad++; $display("FAIL abort_release got gnt=%b busy=%b exp 0000/0", bus.gnt_out, bus.busy); end
    step(0, 4'b1111, 0, 0, 0);
    total++; if (bus.gnt_out !== 4'b0100) begin bad++; $display("FAIL abort_ptr_advance got=%b exp=0100", bus.gnt_out); end
    step(0, 4'b1111, 1, 0, 0);
    step(1, 4'b1111, 0, 0, 0);
    total++; if (bus.gnt_out !== 4'b0000 || bus.busy !== 1'b0) begin bad++; $display("FAIL mid_pkt_reset_gnt got gnt=%b busy=%b exp 0000/0", bus.gnt_out, bus.busy); end
    total++; if (bus.credit_cnt !== 3'd4 || bus.err !== 1'b0) begin bad++; $display("FAIL mid_pkt_reset_cnt got cnt=%0d err=%b exp 4/0", bus.credit_cnt, bus.err); end
  endtask

  task automatic test_fairness();
    logic [3:0] exp;
    step(1, 4'b0000, 0, 0, 0);
    for (int p = 0; p < 8; p++) begin
      exp = 4'(1 << (p % 4));
      step(0, 4'b1111, 0, 0, 0);
      total++; if (bus.gnt_out !== exp) begin bad++; $display("FAIL fair_pkt%0d got=%b exp=%b", p, bus.gnt_out, exp); end
      step(0, 4'b1111, 1, 1, 1);
      total++; if (bus.gnt_out !== 4'b0000) begin bad++; $display("FAIL fair_gap%0d got=%b exp=0000", p, bus.gnt_out); end
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    bit f, t, c, rs;
    step(1, 4'b0000, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      rs = ($urandom_range(0, 79) == 0);
      r  = 4'($urandom_range(0, 15));
      if (m_busy && $urandom_range(0, 9) != 0) r[m_win] = 1'b1;
      f  = m_busy ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 49) == 0);
      t  = ($urandom_range(0, 3) == 0);
      c  = ($urandom_range(0, 2) == 0);
      step(rs, r, f, t, c);
      total++;
      if (bus.gnt_out !== m_gnt || bus.busy !== m_busy || bus.credit_cnt !== 3'(m_cnt) ||
          bus.credit_ok !== (m_cnt != 0) || bus.err !== m_err) begin
        bad++;
        $display("FAIL rand_cyc%0d got gnt=%b busy=%b cnt=%0d ok=%b err=%b exp gnt=%b busy=%b cnt=%0d ok=%b err=%b",
                 i, bus.gnt_out, bus.busy, bus.credit_cnt, bus.credit_ok, bus.err,
                 m_gnt, m_busy, m_cnt, (m_cnt != 0), m_err);
      end
    end
  endtask

  initial begin
    bus.req_in = '0; bus.flit_vld_in = 0; bus.tail_in = 0; bus.credit_in = 0;
    #1;
    test_reset();
    test_grant_and_rr();
    test_credit_exhaust();
    test_same_cycle_and_overflow();
    test_abort_and_reset();
    test_fairness();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
